// File: rtl/operand_sequencer.sv
// Multi-beat register-address sequencer: turns one accepted instruction into one or more
// registered beats of read/write addresses for the register file.
module operand_sequencer #(
    parameter int NREGS  = 16,
    parameter int REG_AW = 4,
    parameter int WP     = 1,
    parameter int PC_IDX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       Instr,
    input  logic [1:0]        RegSrc,
    input  logic              IsMovt,
    input  logic              IsMovm,
    output logic              busy,
    output logic              valid,
    output logic              last,
    output logic [REG_AW-1:0] step_idx,
    output logic [REG_AW-1:0] RA1,
    output logic [REG_AW-1:0] RA2,
    output logic [REG_AW-1:0] WA3,
    output logic [REG_AW-1:0] WA4,
    output logic              we3,
    output logic              we4,
    output logic              isMul,
    output logic              mul_long,
    output logic              is_blk
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SINGLE = 3'd1;
    localparam logic [2:0] S_MLO    = 3'd2;
    localparam logic [2:0] S_MHI    = 3'd3;
    localparam logic [2:0] S_BLK    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [1:0]        regsrc_q, regsrc_d;
    logic              movt_q, movt_d, movm_q, movm_d;
    logic [NREGS-1:0]  rem_q, rem_d;
    logic [REG_AW-1:0] step_q, step_d;
    logic              valid_q, valid_d, last_q, last_d, busy_q, busy_d;
    logic [REG_AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d, wa4_q, wa4_d;
    logic              we3_q, we3_d, we4_q, we4_d;
    logic              is_mul_q, is_mul_d, mul_long_q, mul_long_d, is_blk_q, is_blk_d;

    logic              accept;
    logic [31:0]       cur_instr;
    logic              dec_mul, dec_long, dec_blk;
    logic [NREGS-1:0]  beat_list;
    logic [REG_AW-1:0] blk_idx;
    logic              unused_bits;

    function automatic logic [REG_AW-1:0] lowest_idx(input logic [NREGS-1:0] v);
        logic [REG_AW-1:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (v[i]) idx = REG_AW'(i);
        end
        return idx;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        // valid and busy are always equal, so "not busy" is simply "no beat on the outputs"
        accept    = start && (!valid_q || last_q);
        cur_instr = accept ? Instr : instr_q;
        instr_d   = cur_instr;
        regsrc_d  = accept ? RegSrc : regsrc_q;
        movt_d    = accept ? IsMovt : movt_q;
        movm_d    = accept ? IsMovm : movm_q;

        dec_long = (cur_instr[27:23] == 5'b00001) && (cur_instr[7:4] == 4'b1001);
        dec_mul  = (cur_instr[27:22] == 6'b000000) && (cur_instr[7:4] == 4'b1001);
        dec_blk  = (cur_instr[27:25] == 3'b100);

        state_d    = S_IDLE;
        step_d     = '0;
        beat_list  = '0;
        is_mul_d   = is_mul_q;
        mul_long_d = mul_long_q;
        is_blk_d   = is_blk_q;

        if (accept) begin
            beat_list  = cur_instr[NREGS-1:0];
            is_mul_d   = dec_mul;
            mul_long_d = dec_long;
            is_blk_d   = dec_blk;
            if (dec_blk)       state_d = S_BLK;
            else if (dec_long) state_d = S_MLO;
            else               state_d = S_SINGLE;
        end else if (valid_q && !last_q) begin
            // only MLO and BLK beats can be non-final
            beat_list = rem_q;
            step_d    = step_q + REG_AW'(1);
            state_d   = (state_q == S_MLO) ? S_MHI : S_BLK;
        end

        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        ra1_d   = '0;
        ra2_d   = '0;
        wa3_d   = '0;
        wa4_d   = '0;
        we3_d   = 1'b0;
        we4_d   = 1'b0;
        rem_d   = '0;
        blk_idx = lowest_idx(beat_list);

        case (state_d)
            S_SINGLE: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                last_d  = 1'b1;
                we3_d   = 1'b1;
                wa3_d   = cur_instr[15:12];
                if (dec_mul)                 ra1_d = cur_instr[11:8];
                else if (movt_d || movm_d)   ra1_d = cur_instr[15:12];
                else if (regsrc_d[0])        ra1_d = REG_AW'(PC_IDX);
                else                         ra1_d = cur_instr[19:16];
                if (!dec_mul && regsrc_d[1]) ra2_d = cur_instr[15:12];
                else                         ra2_d = cur_instr[3:0];
            end
            S_MLO, S_MHI: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                we3_d   = 1'b1;
                ra1_d   = cur_instr[11:8];
                ra2_d   = cur_instr[3:0];
                if (state_d == S_MHI) begin
                    wa3_d  = cur_instr[19:16];
                    last_d = 1'b1;
                end else begin
                    wa3_d = cur_instr[15:12];
                    if (WP == 2) begin
                        last_d = 1'b1;
                        we4_d  = 1'b1;
                        wa4_d  = cur_instr[19:16];
                    end
                end
            end
            S_BLK: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                ra1_d   = cur_instr[19:16];
                // clear the lowest set bit; the beat is last once nothing remains
                rem_d   = beat_list & (beat_list - {{(NREGS-1){1'b0}}, 1'b1});
                last_d  = (rem_d == '0);
                if (beat_list != '0) begin
                    ra2_d = blk_idx;
                    wa3_d = blk_idx;
                    we3_d = cur_instr[20];
                end
            end
            default: ;
        endcase
    end

    assign unused_bits = ^{cur_instr[31:28], cur_instr[21]};

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            regsrc_q   <= '0;
            movt_q     <= 1'b0;
            movm_q     <= 1'b0;
            rem_q      <= '0;
            step_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            wa3_q      <= '0;
            wa4_q      <= '0;
            we3_q      <= 1'b0;
            we4_q      <= 1'b0;
            is_mul_q   <= 1'b0;
            mul_long_q <= 1'b0;
            is_blk_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            regsrc_q   <= regsrc_d;
            movt_q     <= movt_d;
            movm_q     <= movm_d;
            rem_q      <= rem_d;
            step_q     <= step_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            wa3_q      <= wa3_d;
            wa4_q      <= wa4_d;
            we3_q      <= we3_d;
            we4_q      <= we4_d;
            is_mul_q   <= is_mul_d;
            mul_long_q <= mul_long_d;
            is_blk_q   <= is_blk_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign last     = last_q;
    assign step_idx = step_q;
    assign RA1      = ra1_q;
    assign RA2      = ra2_q;
    assign WA3      = wa3_q;
    assign WA4      = wa4_q;
    assign we3      = we3_q;
    assign we4      = we4_q;
    assign isMul    = is_mul_q;
    assign mul_long = mul_long_q;
    assign is_blk   = is_blk_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: one WP=1 instance for most sequences and a WP=2
// instance for the single-beat long multiply.
module tb_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [1:0]  reg_src = 2'b00;
    logic        is_movt = 1'b0;
    logic        is_movm = 1'b0;

    logic       busy, valid, last, we3, we4, is_mul, mul_long, is_blk;
    logic [3:0] step_idx, ra1, ra2, wa3, wa4;
    logic       b_busy, b_valid, b_last, b_we3, b_we4, b_is_mul, b_mul_long, b_is_blk;
    logic [3:0] b_step_idx, b_ra1, b_ra2, b_wa3, b_wa4;

    int checks = 0;
    int failures = 0;

    operand_sequencer #(.NREGS(16), .REG_AW(4), .WP(1), .PC_IDX(15)) u_wp1 (
        .clk(clk), .reset_n(reset_n), .start(start), .Instr(instr), .RegSrc(reg_src),
        .IsMovt(is_movt), .IsMovm(is_movm), .busy(busy), .valid(valid), .last(last),
        .step_idx(step_idx), .RA1(ra1), .RA2(ra2), .WA3(wa3), .WA4(wa4), .we3(we3),
        .we4(we4), .isMul(is_mul), .mul_long(mul_long), .is_blk(is_blk)
    );

    operand_sequencer #(.NREGS(16), .REG_AW(4), .WP(2), .PC_IDX(15)) u_wp2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .Instr(instr), .RegSrc(reg_src),
        .IsMovt(is_movt), .IsMovm(is_movm), .busy(b_busy), .valid(b_valid), .last(b_last),
        .step_idx(b_step_idx), .RA1(b_ra1), .RA2(b_ra2), .WA3(b_wa3), .WA4(b_wa4), .we3(b_we3),
        .we4(b_we4), .isMul(b_is_mul), .mul_long(b_mul_long), .is_blk(b_is_blk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'b0, valid}, 32'd0);
        check({tag, ".busy"}, {31'b0, busy}, 32'd0);
        check({tag, ".last"}, {31'b0, last}, 32'd0);
        check({tag, ".step"}, {28'b0, step_idx}, 32'd0);
        check({tag, ".addr"}, {16'b0, ra1, ra2, wa3, wa4}, 32'd0);
        check({tag, ".we"}, {30'b0, we3, we4}, 32'd0);
    endtask

    task automatic check_beat(input string tag, input int e_last, input int e_step,
                              input int e_ra1, input int e_ra2, input int e_wa3, input int e_we3);
        check({tag, ".valid"}, {31'b0, valid}, 32'd1);
        check({tag, ".busy"}, {31'b0, busy}, 32'd1);
        check({tag, ".last"}, {31'b0, last}, e_last);
        check({tag, ".step"}, {28'b0, step_idx}, e_step);
        check({tag, ".ra1"}, {28'b0, ra1}, e_ra1);
        check({tag, ".ra2"}, {28'b0, ra2}, e_ra2);
        check({tag, ".wa3"}, {28'b0, wa3}, e_wa3);
        check({tag, ".we3"}, {31'b0, we3}, e_we3);
        check({tag, ".we4"}, {31'b0, we4}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ldm_regs [4];
        ldm_regs = '{4'd1, 4'd2, 4'd4, 4'd15};

        tick;
        tick;
        check_idle("reset");
        check("reset.flags", {29'b0, is_mul, mul_long, is_blk}, 32'd0);
        reset_n = 1'b1;
        tick;
        check_idle("post_reset");

        // SUB r2, r1, r3
        instr = 32'hE0412003;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_beat("sub", 1, 0, 1, 3, 2, 1);
        check("sub.flags", {29'b0, is_mul, mul_long, is_blk}, 32'd0);
        tick;
        check_idle("sub_end");

        reg_src = 2'b11;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_beat("regsrc", 1, 0, 15, 2, 2, 1);
        tick;
        reg_src = 2'b01;
        is_movt = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        is_movt = 1'b0;
        check_beat("movt", 1, 0, 2, 3, 2, 1);
        tick;
        reg_src = 2'b11;
        instr = 32'hE0012394;
        start = 1'b1;
        tick;
        start = 1'b0;
        reg_src = 2'b00;
        check_beat("mul", 1, 0, 3, 4, 2, 1);
        check("mul.flags", {29'b0, is_mul, mul_long, is_blk}, 32'd4);
        tick;
        check_idle("mul_end");

        // UMULL on one write port; start held high carries a SUB
        instr = 32'hE0821394;
        start = 1'b1;
        tick;
        instr = 32'hE0412003;
        check_beat("umull_lo", 0, 0, 3, 4, 1, 1);
        check("umull_lo.flags", {29'b0, is_mul, mul_long, is_blk}, 32'd2);
        tick;
        check_beat("umull_hi", 1, 1, 3, 4, 2, 1);
        tick;
        start = 1'b0;
        check_beat("b2b_sub", 1, 0, 1, 3, 2, 1);
        check("b2b_sub.mul_long", {31'b0, mul_long}, 32'd0);
        tick;
        check_idle("b2b_end");

        instr = 32'hE0821394;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("wp2.valid_last", {30'b0, b_valid, b_last}, 32'd3);
        check("wp2.addr", {16'b0, b_ra1, b_ra2, b_wa3, b_wa4}, 32'h3412);
        check("wp2.we", {30'b0, b_we3, b_we4}, 32'd3);
        check("wp1_idle.valid", {31'b0, valid}, 32'd0);
        tick;
        check("wp2_end.valid_we4", {30'b0, b_valid, b_we4}, 32'd0);

        // LDM r0, {r1,r2,r4,r15} then the STM variant
        instr = 32'hE8908016;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("ldm%0d", i), (i == 3) ? 1 : 0, i, 0,
                       int'(ldm_regs[i]), int'(ldm_regs[i]), 1);
            check($sformatf("ldm%0d.is_blk", i), {31'b0, is_blk}, 32'd1);
            tick;
        end
        check_idle("ldm_end");

        instr = 32'hE8808016;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("stm%0d", i), (i == 3) ? 1 : 0, i, 0,
                       int'(ldm_regs[i]), int'(ldm_regs[i]), 0);
            tick;
        end
        check_idle("stm_end");

        instr = 32'hE8830000;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_beat("stm_empty", 1, 0, 3, 0, 0, 0);
        tick;
        check_idle("stm_empty_end");

        instr = 32'hE890FFFF;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_beat($sformatf("ldm_full%0d", i), (i == 15) ? 1 : 0, i, 0, i, i, 1);
            tick;
        end
        check_idle("ldm_full_end");

        // async reset during beat 3 of a block transfer
        instr = 32'hE8908016;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        check("rst_mid.pre_step", {28'b0, step_idx}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("rst_mid");
        check("rst_mid.is_blk", {31'b0, is_blk}, 32'd0);
        #1;
        reset_n = 1'b1;
        tick;
        check_idle("rst_next");
        instr = 32'hE0412003;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_beat("rst_fresh_sub", 1, 0, 1, 3, 2, 1);
        tick;
        check_idle("rst_fresh_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
